// File: rtl/prog_loader.sv
// prog_loader: streams a length-prefixed byte image into memory from address 0, then enables the CPU.
// Optional trailing checksum byte is enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int pDATA_WIDTH = 8,
    parameter int pADDR_WIDTH = 8
) (
    input  logic                   iclk,
    input  logic                   irst_n,
    input  logic                   istart,
    input  logic                   iabort,
    input  logic [pDATA_WIDTH-1:0] idata,
    input  logic                   ivalid,
    output logic                   oready,
    output logic                   owr_en,
    output logic [pADDR_WIDTH-1:0] owr_addr,
    output logic [pDATA_WIDTH-1:0] owr_data,
    output logic                   ocpu_en,
    output logic                   obusy,
    output logic                   odone,
    output logic                   oerr
);

`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_LOAD, S_CHECK, S_DONE, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_LOAD, S_DONE} state_t;
`endif

    localparam int CW = pADDR_WIDTH + 1;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [pDATA_WIDTH-1:0] len_q, len_d;
    logic                   wr_en_q, wr_en_d;
    logic [pADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [pDATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                   busy;
    logic                   accept;
    logic                   last_word;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [pDATA_WIDTH-1:0] sum_q, sum_d;
`endif

`ifdef PROG_LOADER_CHECKSUM_EN
    assign busy = (state_q == S_LEN) || (state_q == S_LOAD) || (state_q == S_CHECK);
`else
    assign busy = (state_q == S_LEN) || (state_q == S_LOAD);
`endif
    assign accept = ivalid && busy;
    // The counter is one bit wider than the address so N = 2**pADDR_WIDTH still terminates.
    assign last_word = (cnt_q == CW'(len_q));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_d     = sum_q;
`endif
        if (iabort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (istart) begin
                        state_d = S_LEN;
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum_d   = '0;
`endif
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                S_ERR: begin
                    if (istart) begin
                        state_d = S_LEN;
                        sum_d   = '0;
                    end
                end
`endif
                S_LEN: begin
                    if (accept) begin
                        len_d   = idata;
                        cnt_d   = '0;
                        state_d = S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cnt_q[pADDR_WIDTH-1:0];
                        wr_data_d = idata;
                        cnt_d     = cnt_q + CW'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum_d     = sum_q + idata;
                        if (last_word) state_d = S_CHECK;
`else
                        if (last_word) state_d = S_DONE;
`endif
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (accept) state_d = (idata == sum_q) ? S_DONE : S_ERR;
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q     <= sum_d;
`endif
        end
    end

    // Status outputs decode the state register directly, so they change on the same edge as the state.
    assign oready   = busy;
    assign obusy    = busy;
    assign odone    = (state_q == S_DONE);
    assign ocpu_en  = (state_q == S_DONE);
`ifdef PROG_LOADER_CHECKSUM_EN
    assign oerr     = (state_q == S_ERR);
`else
    assign oerr     = 1'b0;
`endif
    assign owr_en   = wr_en_q;
    assign owr_addr = wr_addr_q;
    assign owr_data = wr_data_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: a byte-count based model checked every cycle, plus literal end-of-test checks.
// Adapts to the PROG_LOADER_CHECKSUM_EN build option.
module tb_prog_loader;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic       iclk;
    logic       irst_n;
    logic       istart;
    logic       iabort;
    logic [7:0] idata;
    logic       ivalid;
    logic       oready;
    logic       owr_en;
    logic [7:0] owr_addr;
    logic [7:0] owr_data;
    logic       ocpu_en;
    logic       obusy;
    logic       odone;
    logic       oerr;

    prog_loader #(.pDATA_WIDTH(8), .pADDR_WIDTH(8)) dut (
        .iclk(iclk), .irst_n(irst_n), .istart(istart), .iabort(iabort),
        .idata(idata), .ivalid(ivalid), .oready(oready), .owr_en(owr_en),
        .owr_addr(owr_addr), .owr_data(owr_data), .ocpu_en(ocpu_en),
        .obusy(obusy), .odone(odone), .oerr(oerr)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: a session is described only by how many bytes it has accepted so far.
    logic       m_active;
    logic [1:0] m_result;   // 0 none, 1 done, 2 error
    logic       m_wr;
    logic [7:0] m_addr, m_data, m_sum;
    int         m_nacc, m_len;

    always @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            m_active <= 1'b0; m_result <= 2'd0; m_wr <= 1'b0;
            m_addr <= 8'h00; m_data <= 8'h00; m_sum <= 8'h00;
            m_nacc <= 0; m_len <= 0;
        end else begin
            m_wr <= 1'b0;
            if (iabort) begin
                m_active <= 1'b0;
                m_result <= 2'd0;
            end else if (m_active) begin
                if (ivalid) begin
                    m_nacc <= m_nacc + 1;
                    if (m_nacc == 0) begin
                        m_len <= int'(idata) + 1;
                    end else if (m_nacc <= m_len) begin
                        m_wr   <= 1'b1;
                        m_addr <= 8'(m_nacc - 1);
                        m_data <= idata;
                        m_sum  <= m_sum + idata;
                        if (m_nacc == m_len && !CK) begin
                            m_active <= 1'b0;
                            m_result <= 2'd1;
                        end
                    end else begin
                        m_active <= 1'b0;
                        m_result <= (idata == m_sum) ? 2'd1 : 2'd2;
                    end
                end
            end else if (istart) begin
                m_active <= 1'b1;
                m_result <= 2'd0;
                m_nacc   <= 0;
                m_sum    <= 8'h00;
            end
        end
    end

    logic cmp_on = 1'b0;
    initial forever begin
        @(negedge iclk);
        if (cmp_on && irst_n) begin
            chk("oready",  32'(oready),  32'(m_active));
            chk("obusy",   32'(obusy),   32'(m_active));
            chk("odone",   32'(odone),   32'(m_result == 2'd1));
            chk("ocpu_en", 32'(ocpu_en), 32'(m_result == 2'd1));
            chk("oerr",    32'(oerr),    32'(m_result == 2'd2));
            chk("owr_en",  32'(owr_en),  32'(m_wr));
            if (m_wr) begin
                chk("owr_addr", 32'(owr_addr), 32'(m_addr));
                chk("owr_data", 32'(owr_data), 32'(m_data));
            end
        end
    end

    logic [7:0] dut_mem [256];
    int         wr_count = 0;
    logic [7:0] last_addr = 8'h00;
    logic [7:0] last_data = 8'h00;
    initial forever begin
        @(negedge iclk);
        if (irst_n && owr_en) begin
            dut_mem[owr_addr] = owr_data;
            last_addr = owr_addr;
            last_data = owr_data;
            wr_count++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge iclk);
    endtask

    task automatic start_pulse();
        istart = 1'b1;
        @(negedge iclk);
        istart = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        ivalid = 1'b1;
        idata  = b;
        @(negedge iclk);
        ivalid = 1'b0;
    endtask

    task automatic basic_image(input logic [7:0] cks);
        start_pulse();
        send(8'h03); send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD4);
        send(cks);
        idle(2);
    endtask

    logic [7:0] bp_sum;

    initial begin
        irst_n = 1'b0; istart = 1'b0; iabort = 1'b0; idata = 8'h00; ivalid = 1'b0;
        idle(2);
        chk("rst_oready", 32'(oready), 32'd0);
        chk("rst_owr_en", 32'(owr_en), 32'd0);
        chk("rst_owr_addr", 32'(owr_addr), 32'd0);
        chk("rst_owr_data", 32'(owr_data), 32'd0);
        chk("rst_status", {28'd0, ocpu_en, obusy, odone, oerr}, 32'd0);
        irst_n = 1'b1;
        cmp_on = 1'b1;
        idle(2);

        // Basic load: A1+B2+C3+D4 = 0x2EA, so the trailer is EA.
        wr_count = 0;
        basic_image(8'hEA);
        chk("basic_wr_count", 32'(wr_count), 32'd4);
        chk("basic_mem0", 32'(dut_mem[0]), 32'hA1);
        chk("basic_mem3", 32'(dut_mem[3]), 32'hD4);
        chk("basic_odone", 32'(odone), 32'd1);
        chk("basic_cpu_en", 32'(ocpu_en), 32'd1);
        chk("basic_oerr", 32'(oerr), 32'd0);

        // Bad checksum, then a good image.
        basic_image(8'hEB);
        chk("bad_oerr", 32'(oerr), 32'(CK));
        chk("bad_cpu_en", 32'(ocpu_en), 32'(!CK));
        basic_image(8'hEA);
        chk("recover_odone", 32'(odone), 32'd1);
        chk("recover_oerr", 32'(oerr), 32'd0);

        // Full depth: 256 bytes 00..FF, trailer 0x80.
        wr_count = 0;
        start_pulse();
        send(8'hFF);
        for (int i = 0; i < 256; i++) send(8'(i));
        send(8'h80);
        idle(3);
        chk("full_wr_count", 32'(wr_count), 32'd256);
        chk("full_last_addr", 32'(last_addr), 32'hFF);
        chk("full_last_data", 32'(last_data), 32'hFF);
        chk("full_mem0", 32'(dut_mem[0]), 32'h00);
        chk("full_odone", 32'(odone), 32'd1);

        // Restart from DONE; a start pulse mid-LOAD has no effect.
        start_pulse();
        chk("restart_cpu_en", 32'(ocpu_en), 32'd0);
        chk("restart_obusy", 32'(obusy), 32'd1);
        wr_count = 0;
        send(8'h01);
        istart = 1'b1;
        send(8'h55);
        istart = 1'b0;
        send(8'h66);
        send(8'hBB);
        idle(2);
        chk("restart_wr_count", 32'(wr_count), 32'd2);
        chk("restart_mem1", 32'(dut_mem[1]), 32'h66);
        chk("restart_odone", 32'(odone), 32'd1);

        // Back-pressure: random gaps between bytes 10..17.
        wr_count = 0;
        bp_sum = 8'h00;
        start_pulse();
        send(8'h07);
        for (int i = 0; i < 8; i++) begin
            idle($urandom_range(0, 2));
            send(8'(8'h10 + i));
            bp_sum = bp_sum + 8'(8'h10 + i);
        end
        idle($urandom_range(0, 2));
        send(bp_sum);
        idle(2);
        chk("bp_wr_count", 32'(wr_count), 32'd8);
        for (int i = 0; i < 8; i++) chk("bp_mem", 32'(dut_mem[i]), 32'(8'h10 + i));
        chk("bp_odone", 32'(odone), 32'd1);

        // Abort after two of four data bytes.
        start_pulse();
        send(8'h03); send(8'h01); send(8'h02);
        iabort = 1'b1;
        @(negedge iclk);
        iabort = 1'b0;
        chk("abort_oready", 32'(oready), 32'd0);
        chk("abort_status", {28'd0, ocpu_en, obusy, odone, oerr}, 32'd0);
        idle(2);

        // Asynchronous reset mid-LOAD, between edges while a write strobe is visible.
        start_pulse();
        send(8'h03); send(8'h11);
        #2 irst_n = 1'b0;
        #1;
        chk("arst_oready", 32'(oready), 32'd0);
        chk("arst_owr_en", 32'(owr_en), 32'd0);
        chk("arst_owr_addr", 32'(owr_addr), 32'd0);
        chk("arst_owr_data", 32'(owr_data), 32'd0);
        chk("arst_status", {28'd0, ocpu_en, obusy, odone, oerr}, 32'd0);
        @(negedge iclk);
        #1 irst_n = 1'b1;
        @(negedge iclk);
        wr_count = 0;
        start_pulse();
        send(8'h00); send(8'h42); send(8'h42);
        idle(2);
        chk("post_rst_wr_count", 32'(wr_count), 32'd1);
        chk("post_rst_mem0", 32'(dut_mem[0]), 32'h42);
        chk("post_rst_odone", 32'(odone), 32'd1);

        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
